// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, colours and helpers.
// Optional border test pattern in vga_scanout: VGA_SCANOUT_BORDER_EN.
package vga_timing_pkg;

   localparam int H_VIS  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int V_VIS  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   // Sync windows are [start, end)
   localparam int H_SYNC_START = H_VIS + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VIS + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam logic [7:0] COLOR_BLACK  = 8'h00;
   localparam logic [7:0] COLOR_BORDER = 8'hFF;

   typedef logic [9:0] cnt_t;

   typedef struct packed {
      logic ren;
      cnt_t h;
      cnt_t v;
   } fetch_t;

   function automatic logic in_span(cnt_t x, cnt_t lo, cnt_t hi);
      return (x >= lo) && (x < hi);
   endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Frame-buffer read port between vga_scanout (master) and the
// frame buffer colour map (slave).
interface vga_scanout_if;

   logic        ren;
   logic [10:0] outaddr_x;
   logic [10:0] outaddr_y;
   logic [7:0]  vram_data;

   modport master (
      output ren,
      output outaddr_x,
      output outaddr_y,
      input  vram_data
   );

   modport slave (
      input  ren,
      input  outaddr_x,
      input  outaddr_y,
      output vram_data
   );

endinterface

// File: rtl/pix_tick_gen.sv
// Divide-by-CLK_DIV pixel strobe; o_pix_tick is high on the last
// system clock of every pixel period.
module pix_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic o_pix_tick
);

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

   logic [3:0] r_div_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_div_cnt <= '0;
      else if (r_div_cnt == DIV_LAST)
         r_div_cnt <= '0;
      else
         r_div_cnt <= r_div_cnt + 4'd1;
   end

   assign o_pix_tick = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: timing counters, frame-buffer fetch stage and output stage.
// Define VGA_SCANOUT_BORDER_EN to force a white border test pattern.
module vga_scanout
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int H_VIS   = vga_timing_pkg::H_VIS,
   parameter int H_FP    = vga_timing_pkg::H_FP,
   parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
   parameter int H_BP    = vga_timing_pkg::H_BP,
   parameter int V_VIS   = vga_timing_pkg::V_VIS,
   parameter int V_FP    = vga_timing_pkg::V_FP,
   parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
   parameter int V_BP    = vga_timing_pkg::V_BP
) (
   input  logic          clk,
   input  logic          rst,
   vga_scanout_if.master fb,
   output logic          hsync,
   output logic          vsync,
   output logic [7:0]    rgb,
   output logic          vblank,
   output logic          frame_tick
);

   localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam cnt_t H_LAST = 10'(HT - 1);
   localparam cnt_t V_LAST = 10'(VT - 1);
   localparam cnt_t H_VEND = 10'(H_VIS);
   localparam cnt_t V_VEND = 10'(V_VIS);
   localparam cnt_t HS_LO  = 10'(H_VIS + H_FP);
   localparam cnt_t HS_HI  = 10'(H_VIS + H_FP + H_SYNC);
   localparam cnt_t VS_LO  = 10'(V_VIS + V_FP);
   localparam cnt_t VS_HI  = 10'(V_VIS + V_FP + V_SYNC);

   logic       w_pix_tick;
   logic       w_visible;
   logic       w_border;
   logic [7:0] w_rgb_next;

   cnt_t        r_h;
   cnt_t        r_v;
   fetch_t      r_f;
   logic [10:0] r_addr_x;
   logic [10:0] r_addr_y;
   logic        r_hsync;
   logic        r_vsync;
   logic [7:0]  r_rgb;
   logic        r_vblank;
   logic        r_frame_tick;

   pix_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk        (clk),
      .rst        (rst),
      .o_pix_tick (w_pix_tick)
   );

   assign w_visible = (r_h < H_VEND) && (r_v < V_VEND);

`ifdef VGA_SCANOUT_BORDER_EN
   assign w_border = (r_f.h == '0) || (r_f.h == H_VEND - 10'd1) ||
                     (r_f.v == '0) || (r_f.v == V_VEND - 10'd1);
`else
   assign w_border = 1'b0;
`endif

   assign w_rgb_next = !r_f.ren ? COLOR_BLACK  :
                       w_border ? COLOR_BORDER : fb.vram_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_pix_tick) begin
         r_h <= (r_h == H_LAST) ? '0 : r_h + 10'd1;
         if (r_h == H_LAST)
            r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
      end
   end

   // Fetch stage: address the frame buffer for the current pixel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_f      <= '0;
         r_addr_x <= '0;
         r_addr_y <= '0;
      end else if (w_pix_tick) begin
         r_f      <= '{ren: w_visible, h: r_h, v: r_v};
         r_addr_x <= w_visible ? {1'b0, r_h} : '0;
         r_addr_y <= w_visible ? {1'b0, r_v} : '0;
      end
   end

   // Output stage: one pixel behind fetch, so the 2-clk read has landed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hsync      <= 1'b1;
         r_vsync      <= 1'b1;
         r_rgb        <= COLOR_BLACK;
         r_vblank     <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= 1'b0;
         if (w_pix_tick) begin
            r_hsync      <= !in_span(r_f.h, HS_LO, HS_HI);
            r_vsync      <= !in_span(r_f.v, VS_LO, VS_HI);
            r_rgb        <= w_rgb_next;
            r_vblank     <= (r_f.v >= V_VEND);
            r_frame_tick <= (r_f.v >= V_VEND) && !r_vblank;
         end
      end
   end

   assign fb.ren       = r_f.ren;
   assign fb.outaddr_x = r_addr_x;
   assign fb.outaddr_y = r_addr_y;
   assign hsync        = r_hsync;
   assign vsync        = r_vsync;
   assign rgb          = r_rgb;
   assign vblank       = r_vblank;
   assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: full-size instance for line timing and
// pixel data, reduced-timing instance for frame, border and reset checks.
module tb_vga_scanout;

`ifdef VGA_SCANOUT_BORDER_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   localparam logic [7:0] BCOL = BORDER ? 8'hFF : 8'h00;
   localparam logic [34:0] RST_VAL =
      {1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   int   ft_cnt;
   int   ft_base;

   logic       hs_d, vs_d, vb_d, ft_d;
   logic [7:0] rgb_d;
   logic       hs_s, vs_s, vb_s, ft_s;
   logic [7:0] rgb_s;
   logic [7:0] d1, d2;

   vga_scanout_if fb_d ();
   vga_scanout_if fb_s ();

   vga_scanout dut_d (
      .clk        (clk),
      .rst        (rst),
      .fb         (fb_d),
      .hsync      (hs_d),
      .vsync      (vs_d),
      .rgb        (rgb_d),
      .vblank     (vb_d),
      .frame_tick (ft_d)
   );

   vga_scanout #(
      .CLK_DIV (4),
      .H_VIS   (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
      .V_VIS   (12), .V_FP (2), .V_SYNC (2), .V_BP (4)
   ) dut_s (
      .clk        (clk),
      .rst        (rst),
      .fb         (fb_s),
      .hsync      (hs_s),
      .vsync      (vs_s),
      .rgb        (rgb_s),
      .vblank     (vb_s),
      .frame_tick (ft_s)
   );

   wire [34:0] out_d = {fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y,
                        hs_d, vs_d, rgb_d, vb_d, ft_d};
   wire [34:0] out_s = {fb_s.ren, fb_s.outaddr_x, fb_s.outaddr_y,
                        hs_s, vs_s, rgb_s, vb_s, ft_s};

   // Frame buffer model: data = column, two clocks after the address
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         d1 <= 8'h00;
         d2 <= 8'h00;
      end else begin
         d1 <= fb_d.outaddr_x[7:0];
         d2 <= d1;
      end
   end
   assign fb_d.vram_data = d2;
   assign fb_s.vram_data = 8'h00;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc    <= 0;
         ft_cnt <= 0;
      end else begin
         cyc <= cyc + 1;
         if (ft_s) ft_cnt <= ft_cnt + 1;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // Returns 1 ns after the k-th rising edge since reset release
   task automatic goto(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (out_d !== RST_VAL) begin
         n_bad++;
         $display("FAIL rst_vals: got %h, expected %h", out_d, RST_VAL);
      end
      rst = 1'b0;
      goto(3);
      n_cmp++;
      if (fb_d.ren !== 1'b0) begin
         n_bad++;
         $display("FAIL pre_tick_ren: got %b, expected 0", fb_d.ren);
      end
      goto(4);
      n_cmp++;
      if ({fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y} !== {1'b1, 22'd0}) begin
         n_bad++;
         $display("FAIL first_fetch: got %b/%0d/%0d, expected 1/0/0",
                  fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y);
      end
      n_cmp++;
      if ({hs_d, vs_d, rgb_d} !== {2'b11, 8'h00}) begin
         n_bad++;
         $display("FAIL first_out: got %b%b/%h, expected 11/00",
                  hs_d, vs_d, rgb_d);
      end
      goto(7);
      n_cmp++;
      if ({hs_d, rgb_d} !== {1'b1, 8'h00}) begin
         n_bad++;
         $display("FAIL hold_out: got %b/%h, expected 1/00", hs_d, rgb_d);
      end
      goto(12);
      n_cmp++;
      if (rgb_d !== (BORDER ? 8'hFF : 8'h01)) begin
         n_bad++;
         $display("FAIL rgb_px1: got %h, expected %h",
                  rgb_d, BORDER ? 8'hFF : 8'h01);
      end
   endtask

   task automatic test_hsync;
      goto(2628);
      n_cmp++;
      if (hs_d !== 1'b1) begin
         n_bad++;
         $display("FAIL hs_655: got %b, expected 1", hs_d);
      end
      goto(2632);
      n_cmp++;
      if (hs_d !== 1'b0) begin
         n_bad++;
         $display("FAIL hs_656: got %b, expected 0", hs_d);
      end
      goto(3012);
      n_cmp++;
      if (hs_d !== 1'b0) begin
         n_bad++;
         $display("FAIL hs_751: got %b, expected 0", hs_d);
      end
      goto(3016);
      n_cmp++;
      if ({hs_d, vs_d} !== 2'b11) begin
         n_bad++;
         $display("FAIL hs_752: got %b%b, expected 11", hs_d, vs_d);
      end
   endtask

   task automatic test_rgb;
      goto(3208);
      n_cmp++;
      if (rgb_d !== BCOL) begin
         n_bad++;
         $display("FAIL rgb_x0: got %h, expected %h", rgb_d, BCOL);
      end
      goto(3608);
      n_cmp++;
      if (rgb_d !== 8'd100) begin
         n_bad++;
         $display("FAIL rgb_x100: got %h, expected 64", rgb_d);
      end
      goto(5764);
      n_cmp++;
      if (rgb_d !== (BORDER ? 8'hFF : 8'd127)) begin
         n_bad++;
         $display("FAIL rgb_x639: got %h, expected %h",
                  rgb_d, BORDER ? 8'hFF : 8'd127);
      end
      goto(5768);
      n_cmp++;
      if (rgb_d !== 8'h00) begin
         n_bad++;
         $display("FAIL rgb_x640: got %h, expected 00", rgb_d);
      end
   endtask

   task automatic test_hsync_period;
      goto(5828);
      n_cmp++;
      if (hs_d !== 1'b1) begin
         n_bad++;
         $display("FAIL hs_l1_655: got %b, expected 1", hs_d);
      end
      goto(5832);
      n_cmp++;
      if (hs_d !== 1'b0) begin
         n_bad++;
         $display("FAIL hs_l1_656: got %b, expected 0", hs_d);
      end
   endtask

   task automatic test_fetch;
      goto(8960);
      n_cmp++;
      if ({fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y}
          !== {1'b1, 11'd639, 11'd2}) begin
         n_bad++;
         $display("FAIL fetch_639: got %b/%0d/%0d, expected 1/639/2",
                  fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y);
      end
      goto(8964);
      n_cmp++;
      if ({fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y} !== {1'b0, 22'd0}) begin
         n_bad++;
         $display("FAIL fetch_640: got %b/%0d/%0d, expected 0/0/0",
                  fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y);
      end
      goto(9600);
      n_cmp++;
      if (fb_d.ren !== 1'b0) begin
         n_bad++;
         $display("FAIL fetch_799: got %b, expected 0", fb_d.ren);
      end
      goto(9604);
      n_cmp++;
      if ({fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y}
          !== {1'b1, 11'd0, 11'd3}) begin
         n_bad++;
         $display("FAIL fetch_wrap: got %b/%0d/%0d, expected 1/0/3",
                  fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y);
      end
   endtask

   task automatic test_vertical;
      goto(10248);
      ft_base = ft_cnt;
      goto(11780);
      n_cmp++;
      if ({vb_s, ft_s} !== 2'b00) begin
         n_bad++;
         $display("FAIL vb_pre: got %b%b, expected 00", vb_s, ft_s);
      end
      goto(11784);
      n_cmp++;
      if ({vb_s, ft_s} !== 2'b11) begin
         n_bad++;
         $display("FAIL vb_rise: got %b%b, expected 11", vb_s, ft_s);
      end
      goto(11785);
      n_cmp++;
      if ({vb_s, ft_s} !== 2'b10) begin
         n_bad++;
         $display("FAIL ft_width: got %b%b, expected 10", vb_s, ft_s);
      end
      goto(11912);
      n_cmp++;
      if (vs_s !== 1'b1) begin
         n_bad++;
         $display("FAIL vs_l13: got %b, expected 1", vs_s);
      end
      goto(12040);
      n_cmp++;
      if (vs_s !== 1'b0) begin
         n_bad++;
         $display("FAIL vs_l14: got %b, expected 0", vs_s);
      end
      goto(12292);
      n_cmp++;
      if (vs_s !== 1'b0) begin
         n_bad++;
         $display("FAIL vs_l15: got %b, expected 0", vs_s);
      end
      goto(12296);
      n_cmp++;
      if (vs_s !== 1'b1) begin
         n_bad++;
         $display("FAIL vs_l16: got %b, expected 1", vs_s);
      end
      goto(12804);
      n_cmp++;
      if (vb_s !== 1'b1) begin
         n_bad++;
         $display("FAIL vb_last: got %b, expected 1", vb_s);
      end
      goto(12808);
      n_cmp++;
      if (vb_s !== 1'b0) begin
         n_bad++;
         $display("FAIL vb_fall: got %b, expected 0", vb_s);
      end
      n_cmp++;
      if (ft_cnt - ft_base !== 1) begin
         n_bad++;
         $display("FAIL ft_count: got %0d, expected 1", ft_cnt - ft_base);
      end
   endtask

   task automatic test_border;
      int at  [6] = '{12828, 13448, 13468, 13508, 13512, 14236};
      logic [7:0] ex [6] = '{BCOL, BCOL, 8'h00, BCOL, 8'h00, BCOL};
      for (int i = 0; i < 6; i++) begin
         goto(at[i]);
         n_cmp++;
         if (rgb_s !== ex[i]) begin
            n_bad++;
            $display("FAIL border_%0d: got %h, expected %h",
                     i, rgb_s, ex[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      goto(16048);
      n_cmp++;
      if ({fb_s.ren, fb_s.outaddr_x, fb_s.outaddr_y}
          !== {1'b1, 11'd11, 11'd5}) begin
         n_bad++;
         $display("FAIL mid_fetch: got %b/%0d/%0d, expected 1/11/5",
                  fb_s.ren, fb_s.outaddr_x, fb_s.outaddr_y);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (out_s !== RST_VAL) begin
         n_bad++;
         $display("FAIL mid_rst_s: got %h, expected %h", out_s, RST_VAL);
      end
      n_cmp++;
      if (out_d !== RST_VAL) begin
         n_bad++;
         $display("FAIL mid_rst_d: got %h, expected %h", out_d, RST_VAL);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      goto(3);
      n_cmp++;
      if (out_s !== RST_VAL) begin
         n_bad++;
         $display("FAIL resume_idle: got %h, expected %h", out_s, RST_VAL);
      end
      goto(4);
      n_cmp++;
      if ({fb_s.ren, fb_s.outaddr_x, fb_s.outaddr_y, rgb_s}
          !== {1'b1, 22'd0, 8'h00}) begin
         n_bad++;
         $display("FAIL resume_00: got %b/%0d/%0d/%h, expected 1/0/0/00",
                  fb_s.ren, fb_s.outaddr_x, fb_s.outaddr_y, rgb_s);
      end
      goto(8);
      n_cmp++;
      if ({fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y}
          !== {1'b1, 11'd1, 11'd0}) begin
         n_bad++;
         $display("FAIL resume_d: got %b/%0d/%0d, expected 1/1/0",
                  fb_d.ren, fb_d.outaddr_x, fb_d.outaddr_y);
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      ft_base = 0;
      rst     = 1'b1;
      test_reset;
      test_hsync;
      test_rgb;
      test_hsync_period;
      test_fetch;
      test_vertical;
      test_border;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side reader for the frame buffer. Generates 640x480@60 VGA timing from a divided system clock, presents the read enable and pixel coordinates to the frame buffer's read port, and aligns the returned colour byte with delayed sync and blanking. Sits between the frame buffer (with its colour-map stage) and the board VGA pins. It is the read-side counterpart of the game logic that writes tiles into the frame buffer.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz to 25 MHz). Legal range 3–16.
- H_VIS / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal timing in pixels.
- V_VIS / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical timing in lines.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- vram_data  in  8  colour byte from the frame buffer colour map. Valid 2 clk after outaddr_x/outaddr_y/ren change.
- ren  out  1  frame-buffer read enable; high while the current pixel is visible.
- outaddr_x  out  11  read column, 0–639.
- outaddr_y  out  11  read row, 0–479.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- rgb  out  8  pixel colour to the DAC pins; 0 during blanking.
- vblank  out  1  high while the output line is 480–524. Game logic may write the frame buffer freely while it is high.
- frame_tick  out  1  one-clk pulse on the first clock of vblank.

## Operation
- Tick generator: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick is high when div_cnt == CLK_DIV-1.
- On each pix_tick, h_cnt advances 0..799 and wraps to 0. When h_cnt wraps, v_cnt advances 0..524 and wraps to 0.
- Fetch stage, registered on pix_tick:
  - visible = (h_cnt < 640) && (v_cnt < 480).
  - ren <= visible.
  - outaddr_x <= visible ? h_cnt : 0; outaddr_y <= visible ? v_cnt : 0.
- Output stage, registered on the next pix_tick: this delays everything by exactly one pixel period relative to fetch.
  - rgb <= fetch-stage ren ? vram_data : 0.
  - hsync <= !(h in 656..751).
  - vsync <= !(v in 490..491).
  - vblank <= (v >= 480).
  - h and v here are the fetch-stage coordinates.
- frame_tick is high for the single clk in which vblank goes 0 to 1.
- All arithmetic is unsigned. Counters are 10 bits internally and zero-extended to 11 bits at the address ports.

## Timing
- Reset values:
  - div_cnt, h_cnt, v_cnt = 0.
  - ren = 0, outaddr_x = 0, outaddr_y = 0.
  - hsync = 1, vsync = 1.
  - rgb = 0, vblank = 0, frame_tick = 0.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). Scanning restarts at pixel (0,0) on the first clk after rst deasserts.
- Pixel data latency: address to rgb is exactly one pixel period (CLK_DIV clk). The frame buffer's 2-clk read latency is absorbed because CLK_DIV >= 3.
- hsync period = 800*CLK_DIV clk; low time = 96*CLK_DIV clk.
- vsync period = 525 lines; low time = 2 lines.
- The sync outputs and rgb change only on the same pix_tick clock edge, so there is no skew between them.

## Configuration
- VGA_SCANOUT_BORDER_EN defined: the output stage forces rgb = 8'hFF on visible pixels where x ∈ {0, 639} or y ∈ {0, 479}. This gives a test pattern for monitor alignment. ren and the addresses are unchanged.
- VGA_SCANOUT_BORDER_EN undefined: rgb always reflects vram_data, as described above.

## Structure
- Shared package vga_timing_pkg holds:
  - the H_*/V_* default constants;
  - derived H_TOTAL = 800 and V_TOTAL = 525;
  - sync start/end positions;
  - colour localparams (COLOR_BLACK = 8'h00, COLOR_BORDER = 8'hFF).
- One sub-module, pix_tick_gen: a divide-by-CLK_DIV counter with async reset that outputs pix_tick.

## Test plan
- Reset, then deassert: first pix_tick occurs at clk 4 (CLK_DIV=4). ren = 1 and outaddr = (0,0) after that tick. hsync = vsync = 1 and rgb = 0 until the next tick.
- Free-run one line: hsync falls at output pixel 656 and rises at 752; period = 3200 clk. ren is low for h_cnt 640–799.
- Model vram_data = outaddr_x[7:0] with 2-clk latency: rgb equals x for pixels 0–639 and is 0 at pixel 640 and beyond, each value one pixel period after its address.
- Full frame: vsync low for lines 490–491 only. frame_tick pulses once when line 480 begins. vblank stays high through line 524 and drops at line 0.
- Assert rst for 1 clk at line 200, pixel 300: every output goes to its reset value within that clk, and the scan resumes at (0,0).
- With VGA_SCANOUT_BORDER_EN defined and vram_data = 8'h00: rgb = 8'hFF on row 0, row 479, column 0 and column 639; 8'h00 everywhere else in the visible area.
